// File: rtl/illegal_instruction_screen_if.sv
// Transfer bundle between pre-decode and the illegal-instruction screen.
// The slave side is the screen; the master side is the fetch/issue environment.
interface illegal_instruction_screen_if #(
    parameter int LANES = 2
);
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic                  in_valid;
    logic                  in_ready;
    logic [32*LANES-1:0]   in_instr;
    logic [LANES-1:0]      in_lane_valid;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES-1:0]      out_illegal;
    logic                  out_any;
    logic [IDX_W-1:0]      out_first_idx;
    logic [31:0]           out_tval;
    logic [LANES-1:0]      out_kill;

    modport master (
        output in_valid, in_instr, in_lane_valid, out_ready,
        input  in_ready, out_valid, out_illegal, out_any, out_first_idx, out_tval, out_kill
    );

    modport slave (
        input  in_valid, in_instr, in_lane_valid, out_ready,
        output in_ready, out_valid, out_illegal, out_any, out_first_idx, out_tval, out_kill
    );
endinterface

// File: rtl/illegal_instruction_screen.sv
// Registered multi-lane illegal-instruction screen: flags lanes outside the enabled
// extension set, reports the oldest offender (mtval) and kills the younger lanes.
module illegal_instruction_screen #(
    parameter int         LANES      = 2,
    parameter bit         USE_MUL    = 1'b1,
    parameter bit         USE_DIV    = 1'b1,
    parameter bit         USE_AMO    = 1'b1,
    parameter bit         USE_RCA    = 1'b1,
    parameter logic [6:0] RCA_MAX_F7 = 7'h0C,
    parameter int         COUNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    illegal_instruction_screen_if.slave bus,
    input  logic [5:0]                  ext_enable,
    input  logic                        flush,
    input  logic                        count_clear,
    output logic [COUNT_W-1:0]          illegal_count
);
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t             state, state_next;
    logic               load;
    logic               in_ready;
    logic               accept;
    logic               deliver;

    logic [LANES-1:0]   illegal_d, illegal_q;
    logic [LANES-1:0]   kill_d, kill_q;
    logic               any_d, any_q;
    logic [IDX_W-1:0]   first_d, first_q;
    logic [31:0]        tval_d, tval_q;
    logic [COUNT_W-1:0] count_q;

    function automatic logic lane_legal(input logic [31:0] ins, input logic [5:0] ext);
        logic [6:0] opcode;
        logic [6:0] funct7;
        logic [2:0] funct3;
        logic [4:0] funct5;
        logic [4:0] rd;
        logic [4:0] rs2;
        logic       legal;
        opcode = ins[6:0];
        rd     = ins[11:7];
        funct3 = ins[14:12];
        rs2    = ins[24:20];
        funct5 = ins[31:27];
        funct7 = ins[31:25];
        legal  = 1'b0;
        case (opcode)
            7'b0110111, 7'b0010111, 7'b1101111: legal = 1'b1;
            7'b1100111: legal = (funct3 == 3'b000);
            7'b1100011: legal = (funct3 != 3'b010) && (funct3 != 3'b011);
            7'b0000011: legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            7'b0100011: legal = funct3 inside {3'b000, 3'b001, 3'b010};
            7'b0010011: begin
                if (funct3 == 3'b001)      legal = (ins[31:26] == 6'b000000);
                else if (funct3 == 3'b101) legal = (ins[31:26] == 6'b000000) || (ins[31:26] == 6'b010000);
                else                       legal = 1'b1;
            end
            7'b0110011: begin
                if (funct7 == 7'b0000000)      legal = 1'b1;
                else if (funct7 == 7'b0100000) legal = (funct3 == 3'b000) || (funct3 == 3'b101);
                else if (funct7 == 7'b0000001) legal = funct3[2] ? (ext[1] && USE_DIV) : (ext[0] && USE_MUL);
                else                           legal = 1'b0;
            end
            7'b0001111: legal = (funct3 == 3'b000) || (funct3 == 3'b001);
            7'b1110011: begin
                if (funct3 != 3'b000 && funct3 != 3'b100) begin
                    legal = 1'b1;
                end else if (funct3 == 3'b000) begin
                    // Privileged ops are matched on the whole word; SFENCE.VMA leaves rs1/rs2 free.
                    legal = (ext[3] && (ins == 32'h00000073 || ins == 32'h00100073 || ins == 32'h30200073))
                         || (ext[4] && (ins == 32'h10200073 || ins == 32'h10500073
                                        || (funct7 == 7'b0001001 && rd == 5'd0)));
                end
            end
            7'b0101111: legal = ext[2] && USE_AMO && (funct3 == 3'b010)
                             && (funct5 inside {5'b00010, 5'b00011, 5'b00001, 5'b00000, 5'b00100,
                                                5'b01100, 5'b01000, 5'b10000, 5'b10100, 5'b11000, 5'b11100})
                             && (funct5 != 5'b00010 || rs2 == 5'd0);
            7'b0101011: legal = ext[5] && USE_RCA && !ins[14] && (funct7 <= RCA_MAX_F7);
            default:    legal = 1'b0;
        endcase
        return legal;
    endfunction

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        illegal_d = '0;
        any_d     = 1'b0;
        first_d   = '0;
        tval_d    = '0;
        kill_d    = '0;
        for (int i = 0; i < LANES; i++) begin
            illegal_d[i] = bus.in_lane_valid[i] && !lane_legal(bus.in_instr[32*i +: 32], ext_enable);
        end
        any_d = |illegal_d;
        // Walk from the youngest lane down so the oldest offender is the last writer.
        for (int i = LANES - 1; i >= 0; i--) begin
            if (illegal_d[i]) begin
                first_d = IDX_W'(i);
                tval_d  = bus.in_instr[32*i +: 32];
            end
        end
        for (int j = 0; j < LANES; j++) begin
            kill_d[j] = any_d && (IDX_W'(j) > first_d);
        end
    end

    assign in_ready = (state == EMPTY) || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;
    assign deliver  = (state == FULL) && bus.out_ready;

    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            EMPTY: if (accept) begin
                state_next = FULL;
                load       = 1'b1;
            end
            FULL: begin
                if (accept)              load       = 1'b1;
                else if (bus.out_ready)  state_next = EMPTY;
            end
            default: state_next = EMPTY;
        endcase
        if (flush) begin
            state_next = EMPTY;
            load       = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_next;
    end

    // NOTE: the payload registers are reset as well, since every output field must read 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= '0;
            any_q     <= 1'b0;
            first_q   <= '0;
            tval_q    <= '0;
            kill_q    <= '0;
        end else if (load) begin
            illegal_q <= illegal_d;
            any_q     <= any_d;
            first_q   <= first_d;
            tval_q    <= tval_d;
            kill_q    <= kill_d;
        end
    end

    // A delivery in the flush cycle still counts: the consumer already took it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   count_q <= '0;
        else if (count_clear)                         count_q <= '0;
        else if (deliver && any_q && count_q != '1)   count_q <= count_q + COUNT_W'(1);
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = (state == FULL);
    assign bus.out_illegal   = illegal_q;
    assign bus.out_any       = any_q;
    assign bus.out_first_idx = first_q;
    assign bus.out_tval      = tval_q;
    assign bus.out_kill      = kill_q;
    assign illegal_count     = count_q;
endmodule

// File: tb/tb_illegal_instruction_screen.sv
// Directed bench for illegal_instruction_screen (LANES=2, COUNT_W=2 so saturation is reachable).
module tb_illegal_instruction_screen;
    localparam logic [31:0] ADD     = 32'h003100B3;
    localparam logic [31:0] MUL     = 32'h023100B3;
    localparam logic [31:0] DIV     = 32'h023140B3;
    localparam logic [31:0] RCA_0C  = 32'h1800002B;
    localparam logic [31:0] RCA_0D  = 32'h1A00002B;
    localparam logic [31:0] RCA_B14 = 32'h1800402B;
    localparam logic [31:0] SRAI_OK = 32'h40315093;
    localparam logic [31:0] SRAI_BD = 32'hC0315093;
    localparam logic [31:0] LR_OK   = 32'h1001202F;
    localparam logic [31:0] LR_BAD  = 32'h1011202F;
    localparam logic [31:0] ECALL   = 32'h00000073;
    localparam logic [31:0] CSRRW   = 32'h30001073;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] ext_enable;
    logic       flush;
    logic       count_clear;
    logic [1:0] illegal_count;
    int         checks = 0;
    int         errors = 0;

    illegal_instruction_screen_if #(.LANES(2)) bus ();

    illegal_instruction_screen #(.LANES(2), .COUNT_W(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .ext_enable    (ext_enable),
        .flush         (flush),
        .count_clear   (count_clear),
        .illegal_count (illegal_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [1:0] ill, input logic first,
                             input logic [31:0] tval, input logic [1:0] kill, input logic [1:0] cnt);
        check({tag, ".valid"},   32'(bus.out_valid),     32'd1);
        check({tag, ".illegal"}, 32'(bus.out_illegal),   32'(ill));
        check({tag, ".any"},     32'(bus.out_any),       32'(ill != 2'b00));
        check({tag, ".first"},   32'(bus.out_first_idx), 32'(first));
        check({tag, ".tval"},    bus.out_tval,           tval);
        check({tag, ".kill"},    32'(bus.out_kill),      32'(kill));
        check({tag, ".count"},   32'(illegal_count),     32'(cnt));
    endtask

    task automatic drive(input logic valid, input logic [31:0] l1, input logic [31:0] l0,
                         input logic [1:0] mask, input logic [5:0] ext);
        bus.in_valid      = valid;
        bus.in_instr      = {l1, l0};
        bus.in_lane_valid = mask;
        ext_enable        = ext;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".valid"},   32'(bus.out_valid),     32'd0);
        check({tag, ".illegal"}, 32'(bus.out_illegal),   32'd0);
        check({tag, ".any"},     32'(bus.out_any),       32'd0);
        check({tag, ".first"},   32'(bus.out_first_idx), 32'd0);
        check({tag, ".tval"},    bus.out_tval,           32'd0);
        check({tag, ".kill"},    32'(bus.out_kill),      32'd0);
        check({tag, ".count"},   32'(illegal_count),     32'd0);
        check({tag, ".in_ready"}, 32'(bus.in_ready),     32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        count_clear   = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 2'b00, 6'h00);
        #1;
        check_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_reset.in_ready", 32'(bus.in_ready), 32'd1);

        // Back-to-back transfers at full throughput; the counter lags delivery by one edge.
        drive(1'b1, MUL, ADD, 2'b11, 6'h3F);        step(); check_out("add_mul_on",    2'b00, 1'b0, 32'd0,   2'b00, 2'd0);
        drive(1'b1, MUL, ADD, 2'b11, 6'h3E);        step(); check_out("mul_off",       2'b10, 1'b1, MUL,     2'b00, 2'd0);
        drive(1'b1, ADD, 32'd0, 2'b11, 6'h3F);      step(); check_out("zero_lane0",    2'b01, 1'b0, 32'd0,   2'b10, 2'd1);
        drive(1'b1, 32'd0, 32'd0, 2'b00, 6'h3F);    step(); check_out("no_lanes",      2'b00, 1'b0, 32'd0,   2'b00, 2'd2);
        drive(1'b1, 32'd0, ADD, 2'b01, 6'h3F);      step(); check_out("invalid_lane1", 2'b00, 1'b0, 32'd0,   2'b00, 2'd2);
        drive(1'b1, RCA_0D, RCA_0C, 2'b11, 6'h3F);  step(); check_out("rca_f7",        2'b10, 1'b1, RCA_0D,  2'b00, 2'd2);
        drive(1'b1, RCA_0C, RCA_B14, 2'b11, 6'h3F); step(); check_out("rca_bit14",     2'b01, 1'b0, RCA_B14, 2'b10, 2'd3);
        drive(1'b1, ADD, RCA_0C, 2'b11, 6'h1F);     step(); check_out("rca_off",       2'b01, 1'b0, RCA_0C,  2'b10, 2'd3);
        drive(1'b1, SRAI_BD, SRAI_OK, 2'b11, 6'h3F); step(); check_out("srai",         2'b10, 1'b1, SRAI_BD, 2'b00, 2'd3);
        drive(1'b1, DIV, MUL, 2'b11, 6'h3D);        step(); check_out("div_off",       2'b10, 1'b1, DIV,     2'b00, 2'd3);
        drive(1'b1, LR_BAD, LR_OK, 2'b11, 6'h3F);   step(); check_out("lr_rs2",        2'b10, 1'b1, LR_BAD,  2'b00, 2'd3);
        drive(1'b1, CSRRW, ECALL, 2'b11, 6'h37);    step(); check_out("ecall_off",     2'b01, 1'b0, ECALL,   2'b10, 2'd3);

        // Clear beats the increment from delivering the illegal ECALL entry.
        count_clear = 1'b1;
        drive(1'b1, ADD, ADD, 2'b11, 6'h3F);        step();
        count_clear = 1'b0;
        check_out("clear", 2'b00, 1'b0, 32'd0, 2'b00, 2'd0);

        drive(1'b1, MUL, ADD, 2'b11, 6'h3E);        step(); check_out("pre_stall", 2'b10, 1'b1, MUL, 2'b00, 2'd0);

        // Stall with a new legal transfer waiting; the held illegal entry must not move.
        bus.out_ready = 1'b0;
        drive(1'b1, ADD, ADD, 2'b11, 6'h3F);
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall.in_ready", 32'(bus.in_ready), 32'd0);
            check_out("stall", 2'b10, 1'b1, MUL, 2'b00, 2'd0);
        end

        bus.out_ready = 1'b1;
        flush         = 1'b1;
        #1;
        check("flush_cycle.in_ready",  32'(bus.in_ready),  32'd1);
        check("flush_cycle.out_valid", 32'(bus.out_valid), 32'd1);
        step();
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 2'b00, 6'h3F);
        check("after_flush.out_valid", 32'(bus.out_valid),     32'd0);
        check("after_flush.count",     32'(illegal_count),     32'd1);
        step();
        check("dropped.out_valid",     32'(bus.out_valid),     32'd0);
        check("dropped.count",         32'(illegal_count),     32'd1);

        // Asynchronous reset in the middle of a stall.
        bus.out_ready = 1'b0;
        drive(1'b1, MUL, ADD, 2'b11, 6'h3E);        step(); check_out("pre_rst", 2'b10, 1'b1, MUL, 2'b00, 2'd1);
        drive(1'b0, 32'd0, 32'd0, 2'b00, 6'h3F);
        #2 rst_n = 1'b0;
        #1;
        check_zero("mid_reset");
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        step();
        check("post_mid_reset.out_valid", 32'(bus.out_valid), 32'd0);
        check("post_mid_reset.in_ready",  32'(bus.in_ready),  32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
